// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the framed byte sender.
// The CKS state only exists when FRAME_TX_CHECKSUM_EN is defined.
package frame_tx_pkg;

`ifdef FRAME_TX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, PAY, CKS, TRL} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;
`endif

    localparam logic [7:0] SOF0 = 8'h7B;
    localparam logic [7:0] SOF1 = 8'h28;
    localparam logic [7:0] EOF0 = 8'h29;
    localparam logic [7:0] EOF1 = 8'h7D;

    // ASCII digit of len, idx 0 = thousands ... 3 = units
    function automatic logic [7:0] len_digit(input int len, input int idx);
        int d;
        case (idx)
            0:       d = (len / 1000) % 10;
            1:       d = (len / 100) % 10;
            2:       d = (len / 10) % 10;
            default: d = len % 10;
        endcase
        return 8'h30 + 8'(d);
    endfunction

endpackage

// File: rtl/frame_tx_fifo.sv
// Single-clock first-word-fall-through byte FIFO, depth 2**FIFO_AW.
module frame_tx_fifo #(
    parameter int FIFO_AW = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);
    logic [7:0]       mem [2**FIFO_AW];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign rd_data = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
        end
    end

endmodule

// File: rtl/frame_stream_tx.sv
// Framed byte sender: header "{(NNNN", PAYLOAD_LEN FIFO bytes, trailer ")}".
// Define FRAME_TX_CHECKSUM_EN to append an XOR checksum byte before the trailer.
module frame_stream_tx
    import frame_tx_pkg::*;
#(
    parameter int PAYLOAD_LEN = 1024,
    parameter int FIFO_AW     = 11,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              frame_mark,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf
);
    localparam int                PCW      = $clog2(PAYLOAD_LEN + 1);
    localparam logic [PCW-1:0]    PAY_LAST = PCW'(PAYLOAD_LEN - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [7:0]        DIG0     = len_digit(PAYLOAD_LEN, 0);
    localparam logic [7:0]        DIG1     = len_digit(PAYLOAD_LEN, 1);
    localparam logic [7:0]        DIG2     = len_digit(PAYLOAD_LEN, 2);
    localparam logic [7:0]        DIG3     = len_digit(PAYLOAD_LEN, 3);

    state_t         state;
    logic [2:0]     idx;
    logic [PCW-1:0] pay_cnt;
    logic [7:0]     fifo_rd;
    logic           fifo_full;
    logic           fifo_empty;
    logic           slot_free;
    logic           pop;
    logic           start;
    logic           done_evt;
`ifdef FRAME_TX_CHECKSUM_EN
    logic [7:0]     cks_acc;
`endif

    function automatic logic [7:0] hdr_byte(input logic [2:0] i);
        case (i)
            3'd0:    return SOF0;
            3'd1:    return SOF1;
            3'd2:    return DIG0;
            3'd3:    return DIG1;
            3'd4:    return DIG2;
            default: return DIG3;
        endcase
    endfunction

    // Saturating pending-frame step; simultaneous mark and done cancel out
    function automatic logic [PEND_W-1:0] pend_step(input logic [PEND_W-1:0] cur,
                                                    input logic inc, input logic dec);
        if (inc && !dec)
            return (cur == PEND_MAX) ? cur : cur + PEND_W'(1);
        else if (dec && !inc)
            return cur - PEND_W'(1);
        return cur;
    endfunction

    // The output register can take a new byte when empty or being drained this cycle
    assign slot_free = !tx_valid || tx_ready;
    assign pop       = (state == PAY) && slot_free && !fifo_empty;
    assign start     = (state == IDLE) && en && (pend_cnt != '0);
    assign done_evt  = (state == TRL) && slot_free && (idx == 3'd2);
    assign in_ready  = !fifo_full;

    frame_tx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            pay_cnt    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pend_cnt   <= '0;
            ovf        <= 1'b0;
`ifdef FRAME_TX_CHECKSUM_EN
            cks_acc    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= HDR;
                        busy  <= 1'b1;
                        idx   <= '0;
`ifdef FRAME_TX_CHECKSUM_EN
                        cks_acc <= '0;
`endif
                    end
                end
                HDR: begin
                    if (slot_free) begin
                        tx_data  <= hdr_byte(idx);
                        tx_valid <= 1'b1;
                        if (idx == 3'd5) begin
                            state   <= PAY;
                            idx     <= '0;
                            pay_cnt <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                PAY: begin
                    if (pop) begin
                        tx_data  <= fifo_rd;
                        tx_valid <= 1'b1;
`ifdef FRAME_TX_CHECKSUM_EN
                        cks_acc  <= cks_acc ^ fifo_rd;
`endif
                        if (pay_cnt == PAY_LAST)
`ifdef FRAME_TX_CHECKSUM_EN
                            state <= CKS;
`else
                            state <= TRL;
`endif
                        else
                            pay_cnt <= pay_cnt + PCW'(1);
                    end else if (slot_free) begin
                        // Starved: drop valid and wait for data, never pad
                        tx_valid <= 1'b0;
                    end
                end
`ifdef FRAME_TX_CHECKSUM_EN
                CKS: begin
                    if (slot_free) begin
                        tx_data  <= cks_acc;
                        tx_valid <= 1'b1;
                        state    <= TRL;
                    end
                end
`endif
                TRL: begin
                    if (slot_free) begin
                        case (idx)
                            3'd0: begin
                                tx_data  <= EOF0;
                                tx_valid <= 1'b1;
                                idx      <= 3'd1;
                            end
                            3'd1: begin
                                tx_data  <= EOF1;
                                tx_valid <= 1'b1;
                                idx      <= 3'd2;
                            end
                            default: begin
                                tx_valid   <= 1'b0;
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                idx        <= '0;
                                state      <= IDLE;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase

            pend_cnt <= pend_step(pend_cnt, frame_mark, done_evt);
            if ((frame_mark && !done_evt && pend_cnt == PEND_MAX) ||
                (in_valid && fifo_full))
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_stream_tx.sv
// Scoreboard bench for frame_stream_tx with PAYLOAD_LEN=4, FIFO_AW=4, PEND_W=2.
// Expected frames include the XOR byte when FRAME_TX_CHECKSUM_EN is defined.
module tb_frame_stream_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       frame_mark = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       frame_done;
    logic [1:0] pend_cnt;
    logic       ovf;

    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         done_exp = 0;
    bit         rnd_rdy = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    frame_stream_tx #(
        .PAYLOAD_LEN (4),
        .FIFO_AW     (4),
        .PEND_W      (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .frame_mark (frame_mark),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .pend_cnt   (pend_cnt),
        .ovf        (ovf)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    // Sink-side ready: always high, or a fair coin per cycle
    always @(posedge clk) begin
        #1;
        tx_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every accepted byte
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_fd = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_fd    = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte got=%0h exp=none", tx_data);
                end else begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_done) begin
                done_cnt++;
                if (prev_fd)
                    chk("done_pulse_width", 32'(prev_fd), 32'd0);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_fd    = frame_done;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic mark();
        frame_mark = 1'b1;
        cyc();
        frame_mark = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(8'h7B); exp_q.push_back(8'h28);
        exp_q.push_back(8'h30); exp_q.push_back(8'h30);
        exp_q.push_back(8'h30); exp_q.push_back(8'h34);
        exp_q.push_back(b0); exp_q.push_back(b1);
        exp_q.push_back(b2); exp_q.push_back(b3);
`ifdef FRAME_TX_CHECKSUM_EN
        exp_q.push_back(b0 ^ b1 ^ b2 ^ b3);
`endif
        exp_q.push_back(8'h29); exp_q.push_back(8'h7D);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (!(exp_q.size() == 0 && !busy && pend_cnt == 2'd0) && n < budget) begin
            cyc();
            n++;
        end
        chk(nm, 32'(n < budget), 32'd1);
        cyc();
        cyc();
    endtask

    task automatic wait_done_gap(input string nm);
        int n = 0;
        @(negedge clk);
        while (!frame_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_seen"}, 32'(n < 200), 32'd1);
        chk({nm, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({nm, "_restart"}, 32'(busy), 32'd1);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({nm, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({nm, "_pend_cnt"}, 32'(pend_cnt), 32'd0);
        chk({nm, "_ovf"}, 32'(ovf), 32'd0);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) cyc();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        cyc();

        // Basic frame with ready held high
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        mark();
        chk("t1_pend_one", 32'(pend_cnt), 32'd1);
        en = 1'b1;
        wait_idle(100, "t1_complete");
        done_exp += 1;
        chk("t1_done_count", 32'(done_cnt), 32'(done_exp));
        chk("t1_pend_zero", 32'(pend_cnt), 32'd0);

        // Same frame, sink ready toggling randomly
        rnd_rdy = 1'b1;
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        mark();
        wait_idle(400, "t2_complete");
        rnd_rdy = 1'b0;
        done_exp += 1;
        chk("t2_done_count", 32'(done_cnt), 32'(done_exp));

        // Payload starved mid-frame
        wr(8'hAA); wr(8'hBB);
        push_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        mark();
        repeat (50) cyc();
        chk("t3_gap_valid_low", 32'(tx_valid), 32'd0);
        chk("t3_gap_busy", 32'(busy), 32'd1);
        chk("t3_gap_pend", 32'(pend_cnt), 32'd1);
        repeat (50) cyc();
        wr(8'hCC); wr(8'hDD);
        wait_idle(100, "t3_complete");
        done_exp += 1;
        chk("t3_done_count", 32'(done_cnt), 32'(done_exp));

        // Three queued frames released back-to-back
        en = 1'b0;
        for (int f = 0; f < 3; f++) begin
            logic [7:0] base;
            base = 8'(8'h40 + 8'h10 * f);
            wr(base); wr(base + 8'd1); wr(base + 8'd2); wr(base + 8'd3);
            push_frame(base, base + 8'd1, base + 8'd2, base + 8'd3);
            mark();
        end
        chk("t4_pend_three", 32'(pend_cnt), 32'd3);
        chk("t4_no_ovf", 32'(ovf), 32'd0);
        en = 1'b1;
        wait_done_gap("t4_gap1");
        wait_done_gap("t4_gap2");
        cyc();
        wait_idle(200, "t4_complete");
        done_exp += 3;
        chk("t4_done_count", 32'(done_cnt), 32'(done_exp));
        chk("t4_pend_zero", 32'(pend_cnt), 32'd0);

        // Pending counter saturation, then reset in the middle of the payload
        en = 1'b0;
        wr(8'h55); wr(8'h66); wr(8'h77); wr(8'h88);
        push_frame(8'h55, 8'h66, 8'h77, 8'h88);
        repeat (4) mark();
        chk("t5_pend_sat", 32'(pend_cnt), 32'd3);
        chk("t5_ovf", 32'(ovf), 32'd1);
        en = 1'b1;
        begin
            int n = 0;
            while (exp_q.size() > 4 && n < 100) begin
                cyc();
                n++;
            end
            chk("t5_reach_pay", 32'(n < 100), 32'd1);
        end
        chk("t5_in_pay_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        exp_q.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Fresh frame after reset; stale FIFO bytes would show up here
        wr(8'h01); wr(8'h02); wr(8'h04); wr(8'h08);
        push_frame(8'h01, 8'h02, 8'h04, 8'h08);
        mark();
        wait_idle(100, "t6_complete");
        chk("t6_done_since_reset", 32'(done_cnt - done_exp), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_stream_tx.md
Name: frame_stream_tx

Overview:
- Parametrised framed byte sender, next generation of the fixed 1024-byte "{(1024 … )}" serial framer.
- Buffers payload bytes in an internal single-clock FIFO and counts committed frames.
- Emits each frame as a header, PAYLOAD_LEN payload bytes and a trailer, over a valid/ready byte interface to the UART transmitter.
- Sits between the capture/ADC packer and uart_tx; payload length and FIFO depth are parameters, not constants.

Parameters:
- PAYLOAD_LEN, 1024, payload bytes per frame; legal range 1..9999.
- FIFO_AW, 11, FIFO address width; depth = 2**FIFO_AW; must be ≥ PAYLOAD_LEN.
- PEND_W, 3, width of the pending-frame counter; saturates at 2**PEND_W-1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  send enable; gates only the start of a new frame.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO not full.
- frame_mark  in  1  single-cycle pulse; one complete frame has been written.
- tx_data  out  8  byte to UART.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART can accept a byte.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse on acceptance of the last trailer byte.
- pend_cnt  out  PEND_W  committed frames not yet sent.
- ovf  out  1  sticky; write attempted while full, or frame_mark while pend_cnt saturated.

Behaviour:
- Reset values: tx_data=0, tx_valid=0, busy=0, frame_done=0, pend_cnt=0, ovf=0, in_ready=1. FIFO pointers are cleared.
- Reset mid-frame: the frame is abandoned and the FIFO contents are discarded.
- FIFO write: occurs when in_valid && in_ready; in_ready = !full.
- FIFO read timing: first-word-fall-through; data is available the cycle after the write.
- pend_cnt: +1 on frame_mark, −1 on frame_done.
  - frame_mark and frame_done in the same cycle: no change.
  - frame_mark at saturation: count held, ovf set.
- Byte transfer: a byte moves on tx_valid && tx_ready. tx_data and tx_valid are registered and change only after a transfer or when tx_valid is low.
- Header byte sequence: 0x7B, 0x28, then four ASCII decimal digits of PAYLOAD_LEN, zero-padded (1024 → 31 30 32 34; 64 → 30 30 36 34).
- Trailer byte sequence: 0x29, 0x7D.
- FSM states: IDLE, HDR, PAY, TRL (plus CKS with the optional feature).
  - IDLE → HDR when en && pend_cnt≠0. busy rises that cycle, and the first header byte is valid the next cycle.
  - HDR: 6 bytes, index counter 0..5 → PAY.
  - PAY: PAYLOAD_LEN bytes popped from the FIFO. One pop per accepted byte, with zero bubbles when the FIFO is non-empty and tx_ready is held high.
  - PAY on empty FIFO: tx_valid deasserts and the FSM stalls with no timeout. No filler byte is ever sent.
  - TRL: 2 bytes, then frame_done pulses → IDLE.
- Payload counter: width $clog2(PAYLOAD_LEN+1); it does not wrap within a frame.
- en low mid-frame: the current frame completes; only the next start is blocked. This is deliberately different from the previous generation, which aborted.
- tx_ready held low: the FSM holds its state and tx_data stays stable.
- Back-to-back frames: when pend_cnt>1 and en=1, the next frame's header follows the previous trailer with exactly one IDLE cycle.

Optional Feature:
- Macro: FRAME_TX_CHECKSUM_EN.
- Defined:
  - A CKS state is inserted between PAY and TRL.
  - It sends one byte: the XOR of all payload bytes of the frame.
  - The accumulator clears on IDLE → HDR.
  - Frame length becomes PAYLOAD_LEN+9.
- Undefined: no CKS state and no accumulator logic; frame length is PAYLOAD_LEN+8.

Decomposition:
- Package frame_tx_pkg:
  - state enum.
  - ASCII constants SOF0=0x7B, SOF1=0x28, EOF0=0x29, EOF1=0x7D.
  - function returning the ASCII digit of PAYLOAD_LEN for index 0..3.
- One sub-module, frame_tx_fifo: single-clock FWFT FIFO parametrised by FIFO_AW, with full and empty outputs.
- The FSM, counters and output register stay in the top module.

Test Plan:
- PAYLOAD_LEN=4, write bytes 11 22 33 44, pulse frame_mark, en=1, tx_ready=1 → sink receives 7B 28 30 30 30 34 11 22 33 44 29 7D, frame_done one pulse, pend_cnt 1→0.
- Same frame with tx_ready toggling randomly 50% → identical byte sequence, tx_data stable whenever tx_valid && !tx_ready.
- Payload starved: write 2 of 4 bytes, frame_mark, wait 100 cycles, write remaining 2 → tx_valid low during the gap, then the frame completes correctly.
- Three frame_marks with en=0, then en=1 → pend_cnt=3, three consecutive frames, one IDLE cycle between them, pend_cnt ends at 0.
- PEND_W=2: 4 frame_marks → pend_cnt=3, ovf=1. Apply rst_n low mid-PAY → all outputs at reset values, FIFO empty.
- FRAME_TX_CHECKSUM_EN defined, payload 01 02 04 08 → byte 0F precedes 29 7D.
